// File: rtl/pir_pkg.sv
// -----------------------------------------------------------------------------
// pir_pkg
// Shared definitions for the PIR sensor emulator:
//   - one-hot channel state encoding (4 bits)
//   - default timing constants
//   - channel count
// -----------------------------------------------------------------------------
package pir_pkg;

   localparam int NUM_CH = 3;

   localparam int PIR_WARMUP_DEFAULT   = 200;
   localparam int PIR_DEBOUNCE_DEFAULT = 3;
   localparam int PIR_HOLD_DEFAULT     = 50;
   localparam int PIR_BLOCK_DEFAULT    = 20;

   // One-hot channel states; the output is taken straight from the HOLD bit.
   localparam logic [3:0] ST_IDLE   = 4'b0001;
   localparam logic [3:0] ST_DETECT = 4'b0010;
   localparam logic [3:0] ST_HOLD   = 4'b0100;
   localparam logic [3:0] ST_BLOCK  = 4'b1000;
   localparam int         HOLD_BIT  = 2;

endpackage

// File: rtl/pir_channel.sv
// -----------------------------------------------------------------------------
// pir_channel
// One emulated PIR channel: IDLE -> DETECT (debounce) -> HOLD (output high)
// -> BLOCK (lockout) -> IDLE.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   enable       warm-up complete; while low the channel is forced to IDLE
//   motion_in    raw motion stimulus for this channel
//   retrigger_en motion during HOLD restarts the hold when high
//   sensor_out   emulated sensor output (high exactly in HOLD)
// -----------------------------------------------------------------------------
module pir_channel
   import pir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = PIR_HOLD_DEFAULT,
   parameter int BLOCK_CYCLES    = PIR_BLOCK_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic motion_in,
   input  logic retrigger_en,
   output logic sensor_out
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int BW = $clog2(BLOCK_CYCLES + 1);

   // Terminal values: the state is left on the edge where the counter sits at
   // N-1, so each phase lasts exactly N cycles and the counters never wrap.
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BLOCK_LAST = BW'(BLOCK_CYCLES - 1);

   logic [3:0]    state;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic [BW-1:0] block_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         block_cnt <= '0;
      end else if (!enable) begin
         state     <= ST_IDLE;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         block_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               deb_cnt   <= '0;
               hold_cnt  <= '0;
               block_cnt <= '0;
               if (motion_in) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state <= ST_HOLD;
                  end else begin
                     state   <= ST_DETECT;
                     deb_cnt <= DW'(1);
                  end
               end
            end
            ST_DETECT: begin
               if (!motion_in) begin
                  state   <= ST_IDLE;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  state    <= ST_HOLD;
                  deb_cnt  <= '0;
                  hold_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               // Retrigger wins over expiry in the same cycle.
               if (retrigger_en && motion_in) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state     <= ST_BLOCK;
                  hold_cnt  <= '0;
                  block_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_BLOCK: begin
               // Motion is ignored here; debounce only starts back in IDLE.
               if (block_cnt == BLOCK_LAST) begin
                  state     <= ST_IDLE;
                  block_cnt <= '0;
               end else begin
                  block_cnt <= block_cnt + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               deb_cnt   <= '0;
               hold_cnt  <= '0;
               block_cnt <= '0;
            end
         endcase
      end
   end

   // Taken directly from a state flop, so the output cannot glitch.
   assign sensor_out = state[HOLD_BIT];

endmodule

// File: rtl/pir_sensor_model.sv
// -----------------------------------------------------------------------------
// pir_sensor_model
// Three-channel passive-infrared sensor emulator with power-on warm-up.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   motion[2:0]   raw motion stimulus, bit n-1 drives channel n
//   retrigger_en  motion during HOLD restarts the hold when high
//   ready         high once warm-up has completed (until next reset)
//   pir_sensor_1..3  emulated sensor outputs, registered
// -----------------------------------------------------------------------------
module pir_sensor_model
   import pir_pkg::*;
#(
   parameter int WARMUP_CYCLES   = PIR_WARMUP_DEFAULT,
   parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = PIR_HOLD_DEFAULT,
   parameter int BLOCK_CYCLES    = PIR_BLOCK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] motion,
   input  logic              retrigger_en,
   output logic              ready,
   output logic              pir_sensor_1,
   output logic              pir_sensor_2,
   output logic              pir_sensor_3
);

   localparam int             WW        = $clog2(WARMUP_CYCLES + 1);
   localparam logic [WW-1:0]  WARM_LAST = WW'(WARMUP_CYCLES - 1);

   logic [WW-1:0]     warm_cnt;
   logic [NUM_CH-1:0] sensor;

   // Warm-up: ready rises on the WARMUP_CYCLES-th edge after reset release,
   // after which the counter freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_cnt <= '0;
         ready    <= 1'b0;
      end else if (!ready) begin
         warm_cnt <= warm_cnt + 1'b1;
         if (warm_cnt == WARM_LAST) begin
            ready <= 1'b1;
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      pir_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .BLOCK_CYCLES    (BLOCK_CYCLES)
      ) u_channel (
         .clk          (clk),
         .rst          (rst),
         .enable       (ready),
         .motion_in    (motion[ch]),
         .retrigger_en (retrigger_en),
         .sensor_out   (sensor[ch])
      );
   end

   assign pir_sensor_1 = sensor[0];
   assign pir_sensor_2 = sensor[1];
   assign pir_sensor_3 = sensor[2];

endmodule
